// File: rtl/multichannel_event_tagger_pkg.sv
// multichannel_event_tagger_pkg
//   Shared definitions for the event tagger: record type encoding, record
//   field offset helpers and a constant clog2.
//   Record layout (LSB first): timestamp, channel bits, type, wrap, lost.
package multichannel_event_tagger_pkg;

  typedef enum logic {
    REC_TYPE_STROBE = 1'b0,
    REC_TYPE_DELTA  = 1'b1
  } rec_type_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ch_width(input int unsigned strobe_ch,
                                           input int unsigned delta_ch);
    return (strobe_ch > delta_ch) ? strobe_ch : delta_ch;
  endfunction

  function automatic int unsigned rec_ch_lsb(input int unsigned timer_w);
    return timer_w;
  endfunction

  function automatic int unsigned rec_type_bit(input int unsigned timer_w,
                                               input int unsigned ch_w);
    return timer_w + ch_w;
  endfunction

  function automatic int unsigned rec_wrap_bit(input int unsigned timer_w,
                                               input int unsigned ch_w);
    return timer_w + ch_w + 1;
  endfunction

  function automatic int unsigned rec_lost_bit(input int unsigned timer_w,
                                               input int unsigned ch_w);
    return timer_w + ch_w + 2;
  endfunction

  function automatic int unsigned rec_width(input int unsigned timer_w,
                                            input int unsigned ch_w);
    return timer_w + ch_w + 3;
  endfunction

endpackage

// File: rtl/multichannel_event_tagger_fifo.sv
// tag_fifo
//   First-word-fall-through record FIFO. A write is accepted when full if
//   the head is popped on the same edge. rd_data reads as zero when empty.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     wr_en, wr_data      write request and data
//     rd_en               pop head (ignored when empty)
//     rd_data, valid      head record and its presence
//     full, level         occupancy status
module tag_fifo
  import multichannel_event_tagger_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = rd_en & (count_q != '0);
    do_push  = wr_en & ((count_q != LVL_W'(DEPTH)) | do_pop);
    // DEPTH is a power of two, so the pointers wrap on their own.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    valid   = (count_q != '0);
    full    = (count_q == LVL_W'(DEPTH));
    level   = count_q;
    rd_data = valid ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: rtl/multichannel_event_tagger.sv
// multichannel_event_tagger
//   Time-stamps masked strobe pulses, delta-channel level changes and timer
//   rollovers, and queues the resulting records in a FWFT FIFO with a
//   valid/ready output. Events sampled on one edge are written on the next.
//   Optional: MULTICHANNEL_EVENT_TAGGER_LOST_COUNT_EN enables the lost bit
//   and the saturating lost_count; otherwise both read as zero.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     strobe_channels, strobe_mask strobe inputs and per-channel enables
//     delta_channels               level inputs, any change is an event
//     reset_counter                synchronous timer clear
//     capture_operate              enables record writes
//     counter_operate              enables timer increment
//     rec_data, rec_valid, rec_ready  record output handshake
//     fifo_level                   FIFO occupancy
//     lost_count                   saturating dropped-record count
module multichannel_event_tagger
  import multichannel_event_tagger_pkg::*;
#(
  parameter  int unsigned STROBE_CH  = 4,
  parameter  int unsigned DELTA_CH   = 4,
  parameter  int unsigned TIMER_W    = 36,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CH_W       = ch_width(STROBE_CH, DELTA_CH),
  localparam int unsigned REC_W      = rec_width(TIMER_W, CH_W),
  localparam int unsigned LVL_W      = clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [STROBE_CH-1:0] strobe_channels,
  input  logic [DELTA_CH-1:0]  delta_channels,
  input  logic [STROBE_CH-1:0] strobe_mask,
  input  logic                 reset_counter,
  input  logic                 capture_operate,
  input  logic                 counter_operate,
  output logic [REC_W-1:0]     rec_data,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [15:0]          lost_count
);

  localparam int unsigned CH_LSB   = rec_ch_lsb(TIMER_W);
  localparam int unsigned TYPE_BIT = rec_type_bit(TIMER_W, CH_W);
  localparam int unsigned WRAP_BIT = rec_wrap_bit(TIMER_W, CH_W);

  logic [STROBE_CH-1:0] s_masked;
  logic                 delta_chg;
  logic                 strobe_hit;
  logic [CH_W-1:0]      cand_ch;
  rec_type_e            cand_type;

  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [DELTA_CH-1:0]  old_delta_q, old_delta_d;
  logic                 rollover_q, rollover_d;
  logic                 cand_valid_q, cand_valid_d;
  logic [REC_W-2:0]     cand_body_q, cand_body_d;

  logic                 fifo_full;
  logic                 pop_fire;
  logic                 push_ok;
  logic                 lost_bit;
  logic [REC_W-1:0]     fifo_wdata;

  // Candidate selection on the sampling edge; the record is staged and
  // written one edge later, where the lost bit is attached.
  always_comb begin
    s_masked   = strobe_channels & strobe_mask;
    delta_chg  = (delta_channels != old_delta_q);
    strobe_hit = |s_masked;

    cand_ch   = CH_W'(s_masked);
    cand_type = REC_TYPE_STROBE;
    if (delta_chg) begin
      cand_ch   = CH_W'(delta_channels);
      cand_type = REC_TYPE_DELTA;
    end

    cand_valid_d = capture_operate & (delta_chg | strobe_hit | rollover_q);

    cand_body_d                     = '0;
    cand_body_d[TIMER_W-1:0]        = timer_q;
    cand_body_d[CH_LSB +: CH_W]     = cand_ch;
    cand_body_d[TYPE_BIT]           = cand_type;
    cand_body_d[WRAP_BIT]           = (timer_q == '0);

    old_delta_d = delta_channels;

    // The marker goes out (or is discarded with capture off) whenever the
    // strobe path wins; a delta change defers it to a later edge.
    rollover_d = rollover_q & delta_chg;
    if (!reset_counter && counter_operate && (timer_q == '1)) rollover_d = 1'b1;

    timer_d = reset_counter ? '0 : timer_q + TIMER_W'(counter_operate);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q      <= '0;
      old_delta_q  <= '0;
      rollover_q   <= 1'b0;
      cand_valid_q <= 1'b0;
      cand_body_q  <= '0;
    end else begin
      timer_q      <= timer_d;
      old_delta_q  <= old_delta_d;
      rollover_q   <= rollover_d;
      cand_valid_q <= cand_valid_d;
      cand_body_q  <= cand_body_d;
    end
  end

  always_comb begin
    pop_fire   = rec_valid & rec_ready;
    push_ok    = cand_valid_q & (~fifo_full | pop_fire);
    fifo_wdata = {lost_bit, cand_body_q};
  end

`ifdef MULTICHANNEL_EVENT_TAGGER_LOST_COUNT_EN
  logic        collide_q, collide_d;
  logic        lost_pending_q, lost_pending_d;
  logic [15:0] lost_count_q, lost_count_d;
  logic [1:0]  lost_inc;
  logic [16:0] lost_sum;

  always_comb begin
    collide_d      = capture_operate & delta_chg & strobe_hit;
    lost_pending_d = lost_pending_q;
    lost_inc       = 2'd0;
    if (cand_valid_q) begin
      if (push_ok) begin
        lost_pending_d = collide_q;
      end else begin
        lost_pending_d = 1'b1;
        lost_inc       = 2'd1;
      end
      if (collide_q) lost_inc = lost_inc + 2'd1;
    end
    lost_sum     = {1'b0, lost_count_q} + 17'(lost_inc);
    lost_count_d = lost_sum[16] ? '1 : lost_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collide_q      <= 1'b0;
      lost_pending_q <= 1'b0;
      lost_count_q   <= '0;
    end else begin
      collide_q      <= collide_d;
      lost_pending_q <= lost_pending_d;
      lost_count_q   <= lost_count_d;
    end
  end

  assign lost_bit   = lost_pending_q;
  assign lost_count = lost_count_q;
`else
  assign lost_bit   = 1'b0;
  assign lost_count = '0;
`endif

  tag_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_ok),
    .wr_data (fifo_wdata),
    .rd_en   (rec_ready),
    .rd_data (rec_data),
    .valid   (rec_valid),
    .full    (fifo_full),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_multichannel_event_tagger.sv
// Self-checking bench for multichannel_event_tagger (TIMER_W = 8 so that
// timer rollover is reachable). Expected outputs come from a queue-based
// reference model stepped once per clock edge.
module tb_multichannel_event_tagger;

  localparam int unsigned SCH   = 4;
  localparam int unsigned DCH   = 4;
  localparam int unsigned TW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned REC_W = TW + 4 + 3;
`ifdef MULTICHANNEL_EVENT_TAGGER_LOST_COUNT_EN
  localparam bit LOST_EN = 1'b1;
`else
  localparam bit LOST_EN = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic [SCH-1:0]   strobe_channels;
  logic [DCH-1:0]   delta_channels;
  logic [SCH-1:0]   strobe_mask;
  logic             reset_counter;
  logic             capture_operate;
  logic             counter_operate;
  logic [REC_W-1:0] rec_data;
  logic             rec_valid;
  logic             rec_ready;
  logic [4:0]       fifo_level;
  logic [15:0]      lost_count;

  multichannel_event_tagger #(
    .STROBE_CH  (SCH),
    .DELTA_CH   (DCH),
    .TIMER_W    (TW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .strobe_channels (strobe_channels),
    .delta_channels  (delta_channels),
    .strobe_mask     (strobe_mask),
    .reset_counter   (reset_counter),
    .capture_operate (capture_operate),
    .counter_operate (counter_operate),
    .rec_data        (rec_data),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .fifo_level      (fifo_level),
    .lost_count      (lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_timer;
  logic [3:0]       m_old;
  bit               m_roll;
  bit               m_lp;
  int               m_lc;
  bit               pend_v;
  bit               pend_col;
  logic [13:0]      pend_body;
  logic [REC_W-1:0] m_q[$];

  task automatic model_reset();
    m_timer = 0; m_old = '0; m_roll = 0; m_lp = 0; m_lc = 0;
    pend_v = 0; pend_col = 0; pend_body = '0;
    m_q.delete();
  endtask

  task automatic model_edge();
    int         pre;
    bit         popped;
    bit         dchg;
    logic [3:0] s;
    logic [3:0] ch;
    logic [7:0] ts;
    pre    = m_q.size();
    popped = (pre > 0) && rec_ready;
    if (popped) void'(m_q.pop_front());
    if (pend_v) begin
      if (pre < DEPTH || popped) begin
        m_q.push_back({(LOST_EN ? m_lp : 1'b0), pend_body});
        m_lp = pend_col;
      end else begin
        m_lp = 1;
        m_lc++;
      end
      if (pend_col) m_lc++;
      if (m_lc > 65535) m_lc = 65535;
    end
    s        = strobe_channels & strobe_mask;
    dchg     = (delta_channels != m_old);
    pend_v   = 0;
    pend_col = 0;
    if (dchg || s != 0 || m_roll) begin
      ch        = dchg ? delta_channels : s;
      ts        = m_timer[7:0];
      pend_body = {(m_timer == 0), dchg, ch, ts};
      pend_v    = capture_operate;
      pend_col  = capture_operate && dchg && (s != 0);
      if (!dchg) m_roll = 0;
    end
    m_old = delta_channels;
    if (!reset_counter && counter_operate && m_timer == 255) m_roll = 1;
    m_timer = reset_counter ? 0 : (m_timer + int'(counter_operate)) % 256;
  endtask

  task automatic compare_outputs();
    bit nonempty;
    nonempty = (m_q.size() > 0);
    check("rec_valid", 64'(rec_valid), 64'(nonempty));
    check("rec_data", 64'(rec_data), nonempty ? 64'(m_q[0]) : 64'd0);
    check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check("lost_count", 64'(lost_count), LOST_EN ? 64'(m_lc) : 64'd0);
  endtask

  // Inputs change on the falling edge; reset is always released there too.
  task automatic step(input logic [3:0] st, input logic [3:0] dl, input logic [3:0] mask,
                      input logic rc, input logic cap, input logic cop, input logic rdy);
    @(negedge clk);
    reset_n         = 1'b1;
    strobe_channels = st;
    delta_channels  = dl;
    strobe_mask     = mask;
    reset_counter   = rc;
    capture_operate = cap;
    counter_operate = cop;
    rec_ready       = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  int         n_rec;
  int         lc_before;
  logic [3:0] rdl;
  logic [3:0] rst_v;

  initial begin
    reset_n = 1'b0;
    strobe_channels = '0; delta_channels = '0; strobe_mask = 4'b1111;
    reset_counter = 1'b0; capture_operate = 1'b1; counter_operate = 1'b1;
    rec_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_outputs();

    // Basic strobe at timer 100, one-edge write latency.
    repeat (100) step(4'b0000, 4'b0000, 4'b1111, 0, 1, 1, 0);
    step(4'b0101, 4'b0000, 4'b1111, 0, 1, 1, 0);
    check("lat_valid_early", 64'(rec_valid), 64'd0);
    step(4'b0000, 4'b0000, 4'b1111, 0, 1, 1, 0);
    check("first_valid", 64'(rec_valid), 64'd1);
    check("first_rec", 64'(rec_data), 64'h0564);
    step(4'b0000, 4'b0000, 4'b1111, 0, 1, 1, 1);

    // Delta change collides with a strobe.
    lc_before = m_lc;
    step(4'b0001, 4'b0011, 4'b1111, 0, 1, 1, 1);
    step(4'b0000, 4'b0011, 4'b1111, 0, 1, 1, 0);
    check("coll_type", 64'(rec_data[12]), 64'd1);
    check("coll_ch", 64'(rec_data[11:8]), 64'h3);
    check("coll_lost_bit", 64'(rec_data[14]), 64'd0);
    check("coll_lost_cnt", 64'(lost_count), LOST_EN ? 64'(lc_before + 1) : 64'd0);
    step(4'b0000, 4'b0011, 4'b1111, 0, 1, 1, 1);
    step(4'b0001, 4'b0011, 4'b1111, 0, 1, 1, 1);
    step(4'b0000, 4'b0011, 4'b1111, 0, 1, 1, 0);
    check("after_coll_lost", 64'(rec_data[14]), 64'(LOST_EN));
    step(4'b0000, 4'b0011, 4'b1111, 0, 1, 1, 1);

    // Timer rollover: one marker, none while the counter is stopped.
    n_rec = 0;
    for (int i = 0; i < 300; i++) begin
      step(4'b0000, 4'b0011, 4'b1111, 0, 1, 1, 1);
      if (rec_valid) begin
        n_rec++;
        check("marker_rec", 64'(rec_data), 64'h2000);
      end
    end
    check("marker_count", 64'(n_rec), 64'd1);
    n_rec = 0;
    for (int i = 0; i < 300; i++) begin
      step(4'b0000, 4'b0011, 4'b1111, 0, 1, 0, 1);
      if (rec_valid) n_rec++;
    end
    check("marker_stopped", 64'(n_rec), 64'd0);

    // FIFO overflow under back-pressure, then drain.
    lc_before = m_lc;
    for (int i = 0; i < 20; i++) begin
      rst_v = 4'($urandom_range(1, 15));
      step(rst_v, 4'b0011, 4'b1111, 0, 1, 0, 0);
    end
    step(4'b0000, 4'b0011, 4'b1111, 0, 1, 0, 0);
    check("full_level", 64'(fifo_level), 64'd16);
    check("full_lost", 64'(lost_count), LOST_EN ? 64'(lc_before + 4) : 64'd0);
    check("full_head_lost", 64'(rec_data[14]), 64'd0);
    repeat (16) step(4'b0000, 4'b0011, 4'b1111, 0, 1, 0, 1);
    check("drained", 64'(fifo_level), 64'd0);
    step(4'b0010, 4'b0011, 4'b1111, 0, 1, 0, 1);
    step(4'b0000, 4'b0011, 4'b1111, 0, 1, 0, 0);
    check("after_full_lost", 64'(rec_data[14]), 64'(LOST_EN));
    step(4'b0000, 4'b0011, 4'b1111, 0, 1, 0, 1);

    // Mask and capture disable.
    step(4'b0001, 4'b0011, 4'b1110, 0, 1, 0, 1);
    step(4'b0000, 4'b0011, 4'b1110, 0, 1, 0, 1);
    check("masked", 64'(fifo_level), 64'd0);
    step(4'b0000, 4'b0101, 4'b1111, 0, 0, 0, 1);
    step(4'b0000, 4'b0101, 4'b1111, 0, 0, 0, 1);
    step(4'b0000, 4'b0101, 4'b1111, 0, 1, 0, 1);
    step(4'b0000, 4'b0101, 4'b1111, 0, 1, 0, 1);
    check("cap_off_no_rec", 64'(fifo_level), 64'd0);

    // Asynchronous reset with queued records.
    for (int i = 0; i < 5; i++) step(4'b1000, 4'b0101, 4'b1111, 0, 1, 1, 0);
    step(4'b0000, 4'b0101, 4'b1111, 0, 1, 1, 0);
    check("queued5", 64'(fifo_level), 64'd5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(rec_valid), 64'd0);
    check("arst_level", 64'(fifo_level), 64'd0);
    check("arst_data", 64'(rec_data), 64'd0);
    check("arst_lost", 64'(lost_count), 64'd0);
    model_reset();

    // Randomised traffic.
    rdl = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rdl = 4'($urandom);
      step(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
           rdl,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111,
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 7) != 0),
           ((i / 64) % 3 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
